// File: rtl/raster_cmd_queue_if.sv
// raster_cmd_queue_if: CPU-side enqueue port, status flags and rasterizer-side issue port.
interface raster_cmd_queue_if #(
    parameter int DEPTH = 4,
    parameter int CMD_W = 3
);
    localparam int LW = $clog2(DEPTH) + 1;
    logic [CMD_W-1:0] in_command;
    logic [7:0]       in_x0, in_y0, in_x1, in_y1;
    logic [2:0]       in_colour;
    logic             push, flush, clr_overflow;
    logic             full, empty, overflow, idle;
    logic [LW-1:0]    level;
    logic [CMD_W-1:0] command;
    logic [7:0]       x0, y0, x1, y1;
    logic [2:0]       colour;
    logic             execute_request;
    logic             busy;

    modport master (
        output in_command, in_x0, in_y0, in_x1, in_y1, in_colour, push, flush, clr_overflow, busy,
        input  full, empty, overflow, idle, level, command, x0, y0, x1, y1, colour, execute_request
    );

    modport slave (
        input  in_command, in_x0, in_y0, in_x1, in_y1, in_colour, push, flush, clr_overflow, busy,
        output full, empty, overflow, idle, level, command, x0, y0, x1, y1, colour, execute_request
    );
endinterface

// File: rtl/raster_cmd_queue.sv
// raster_cmd_queue: circular command buffer feeding a rasterizer through an IDLE/ISSUE/WAIT handshake.
// Popped entries are held in output registers until the next pop.
module raster_cmd_queue #(
    parameter int DEPTH = 4,
    parameter int CMD_W = 3
) (
    input logic clk,
    input logic n_rst_async,
    raster_cmd_queue_if.slave bus
);
    localparam int AW = $clog2(DEPTH);
    localparam int LW = AW + 1;
    localparam int EW = CMD_W + 35;

    typedef enum logic [1:0] {IDLE, ISSUE, WAIT} state_e;

    state_e        state_q, state_d;
    logic [AW-1:0] wr_q, wr_d, rd_q, rd_d;
    logic [LW-1:0] level_q, level_d;
    logic          overflow_q, overflow_d;
    logic [EW-1:0] out_q, out_d;
    logic [EW-1:0] mem [DEPTH];
    logic          pop, accept, drop, is_full;

    assign is_full = level_q == LW'(DEPTH);

    // flush suppresses the pop so nothing is issued from a queue being discarded
    always_comb begin
        state_d = state_q;
        pop     = 1'b0;
        case (state_q)
            IDLE:    if (level_q != '0 && !bus.busy && !bus.flush) begin
                         pop     = 1'b1;
                         state_d = ISSUE;
                     end
            ISSUE:   state_d = WAIT;
            WAIT:    if (!bus.busy) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        accept     = bus.push && !bus.flush && (!is_full || pop);
        drop       = bus.push && !bus.flush && is_full && !pop;
        wr_d       = wr_q + AW'(accept);
        rd_d       = bus.flush ? wr_q : rd_q + AW'(pop);
        level_d    = bus.flush ? '0 : level_q + LW'(accept) - LW'(pop);
        overflow_d = drop || (overflow_q && !bus.clr_overflow);
        out_d      = pop ? mem[rd_q] : out_q;
    end

    always_ff @(posedge clk or negedge n_rst_async) begin
        if (!n_rst_async) begin
            state_q    <= IDLE;
            wr_q       <= '0;
            rd_q       <= '0;
            level_q    <= '0;
            overflow_q <= 1'b0;
            out_q      <= '0;
        end else begin
            state_q    <= state_d;
            wr_q       <= wr_d;
            rd_q       <= rd_d;
            level_q    <= level_d;
            overflow_q <= overflow_d;
            out_q      <= out_d;
        end
    end

    // storage needs no reset: a slot is only read after it has been written
    always_ff @(posedge clk) begin
        if (accept)
            mem[wr_q] <= {bus.in_command, bus.in_x0, bus.in_y0, bus.in_x1, bus.in_y1, bus.in_colour};
    end

    assign bus.full            = is_full;
    assign bus.empty           = level_q == '0;
    assign bus.level           = level_q;
    assign bus.overflow        = overflow_q;
    assign bus.idle            = level_q == '0 && state_q == IDLE;
    assign bus.execute_request = state_q == ISSUE;
    assign {bus.command, bus.x0, bus.y0, bus.x1, bus.y1, bus.colour} = out_q;
endmodule

// File: doc/raster_cmd_queue.md
RASTER_CMD_QUEUE -- requirements
Module: raster_cmd_queue

Interface
- REQ-001 SHALL have parameter DEPTH, default 4, meaning queue entries (power of two, 2..16).
- REQ-002 SHALL have parameter CMD_W, default 3, meaning bit width of the raster command code.
- REQ-003 SHALL have clk  input  1  system clock (50 MHz); all state changes on its rising edge.
- REQ-004 SHALL have n_rst_async  input  1  reset, asynchronous and active-low.
- REQ-005 SHALL have in_command  input  CMD_W  CPU-side command code.
- REQ-006 SHALL have in_x0, in_y0, in_x1, in_y1  input  8 each  CPU-side coordinates.
- REQ-007 SHALL have in_colour  input  3  CPU-side pixel colour.
- REQ-008 SHALL have push  input  1  enqueue in_* this cycle.
- REQ-009 SHALL have flush  input  1  discard all queued (not yet issued) entries.
- REQ-010 SHALL have clr_overflow  input  1  clear the overflow flag.
- REQ-011 SHALL have full, empty  output  1 each  queue occupancy flags.
- REQ-012 SHALL have level  output  $clog2(DEPTH)+1  queued entry count.
- REQ-013 SHALL have overflow  output  1  sticky: a push was dropped.
- REQ-014 SHALL have idle  output  1  queue empty and no command in flight.
- REQ-015 SHALL have command (CMD_W), x0, y0, x1, y1 (8 each), colour (3)  outputs  rasterizer-side registered command fields.
- REQ-016 SHALL have execute_request  output  1  one-cycle issue strobe to rasterizer.
- REQ-017 SHALL have busy  input  1  rasterizer busy.

Function
- REQ-018 SHALL store entries as {command,x0,y0,x1,y1,colour} in a circular buffer with write/read pointers wrapping modulo DEPTH.
- REQ-019 SHALL accept push when level<DEPTH, or when level==DEPTH and an issue occurs the same cycle; entry visible (level incremented) next cycle.
- REQ-020 SHALL drop a push when level==DEPTH and no issue occurs that cycle, set overflow, leave queue unchanged.
- REQ-021 SHALL clear overflow on clr_overflow; simultaneous drop and clr_overflow leaves overflow=1.
- REQ-022 SHALL implement FSM states IDLE, ISSUE, WAIT.
- REQ-023 IDLE: if level>0 and busy==0, pop head into output registers, go ISSUE; else remain.
- REQ-024 ISSUE: execute_request=1 for exactly this cycle, busy ignored, go WAIT unconditionally.
- REQ-025 WAIT: remain while busy==1; go IDLE on busy==0 (no command issue in the WAIT->IDLE cycle; minimum issue spacing 3 cycles).
- REQ-026 SHALL hold command/x0/y0/x1/y1/colour stable from pop until the next pop.
- REQ-027 SHALL, on flush, set level=0 and pointers equal next cycle; flush wins over same-cycle push (push dropped, overflow not set) and over same-cycle pop (no issue); in-flight ISSUE/WAIT unaffected.
- REQ-028 SHALL drive full=(level==DEPTH), empty=(level==0), idle=(empty and state==IDLE), combinationally from registered state.
- REQ-029 SHALL issue entries in strict push order; a push to an empty queue in IDLE with busy==0 gives execute_request two cycles after push.

Reset
- REQ-030 SHALL, while n_rst_async==0, force state IDLE, pointers 0, level 0, overflow 0, execute_request 0, all command output fields 0, independent of clk.
- REQ-031 SHALL discard queue contents and any in-flight command on reset mid-operation; no execute_request in the first cycle after release.
- REQ-032 SHALL not require buffer storage to be reset (contents unobservable while empty).

Verification
- REQ-033 Single push {cmd=1,x0=10,y0=20,x1=30,y1=40,col=5}, busy=0 -> execute_request high exactly at push+2, outputs equal pushed fields, level 1->0, idle=1 after busy low.
- REQ-034 Five pushes, DEPTH=4, busy held 1 -> first popped, 4 queued, fifth accepted only if pop coincides, else overflow=1; clr_overflow -> overflow=0.
- REQ-035 busy=1 for 10 cycles after each request -> next execute_request no earlier than the cycle after busy falls +1; order preserved over 8 commands with pointer wrap.
- REQ-036 flush with level=3 and same-cycle push while in WAIT -> level=0, no extra requests, in-flight outputs unchanged, overflow=0.
- REQ-037 n_rst_async low mid-WAIT with level=2 -> immediately all outputs 0, level 0; after release with busy=0 no execute_request.
- REQ-038 Push while full and issuing same cycle -> accepted, level stays DEPTH, overflow=0.
